mac_seq_iter: RTL and testbench

Parametrised successor to the team's single-cycle multiply-accumulate block. It uses an iterative radix-2 shift-add multiplier, one operand bit per cycle, instead of a full array multiplier, trading latency for area. It adds a valid/ready input handshake, signed/unsigned mode per operation, a clear-on-accept option, guard bits, optional saturation and a sticky overflow flag. It sits in the datapath as a low-area accumulator for filter/dot-product tiles.

---
 rtl/mac_pkg.sv | 10 +
 rtl/mac_sat_add.sv | 22 ++
 rtl/mac_seq_iter.sv | 74 +++++++
 tb/tb_mac_seq_iter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared FSM state type and saturation limits for the iterative MAC.
package mac_pkg;
  typedef enum logic [1:0] {IDLE, MUL, ACC} mac_state_t;
  function automatic logic [63:0] sat_max(input int w, input logic sgn);
    return sgn ? (64'd1 << (w - 1)) - 64'd1 : (64'd1 << w) - 64'd1;
  endfunction
  function automatic logic [63:0] sat_min(input int w, input logic sgn);
    return sgn ? (~64'd0 << (w - 1)) : 64'd0;
  endfunction
endpackage

// File: rtl/mac_sat_add.sv
// mac_sat_add: accumulator adder with signed/unsigned overflow detection and optional clamping.
module mac_sat_add import mac_pkg::*; #(
  parameter int ACC_WIDTH = 12,
  parameter int SAT = 1
) (
  input  logic [ACC_WIDTH-1:0] base,
  input  logic [ACC_WIDTH:0]   prod,
  input  logic                 signed_mode,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 overflow
);
  logic [ACC_WIDTH:0] sum;
  // one extra bit: its disagreement with the MSB flags signed overflow, alone it is the unsigned carry
  always_comb begin
    sum = {signed_mode & base[ACC_WIDTH-1], base} + prod;
    overflow = signed_mode ? sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1] : sum[ACC_WIDTH];
    result = (SAT != 0 && overflow)
           ? ((signed_mode && sum[ACC_WIDTH]) ? ACC_WIDTH'(sat_min(ACC_WIDTH, signed_mode))
                                              : ACC_WIDTH'(sat_max(ACC_WIDTH, signed_mode)))
           : sum[ACC_WIDTH-1:0];
  end
endmodule

// File: rtl/mac_seq_iter.sv
// mac_seq_iter: multiply-accumulate using a radix-2 shift-add multiplier, one multiplier bit per cycle.
module mac_seq_iter import mac_pkg::*; #(
  parameter int WIDTH = 4,
  parameter int ACC_WIDTH = 2 * WIDTH + 4,
  parameter int SAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  input  logic                 clr,
  output logic [ACC_WIDTH-1:0] acc_q,
  output logic                 out_valid,
  output logic                 ovf
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  mac_state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] mcand, mplier;
  logic [2*WIDTH-1:0] partial, prod_s;
  logic [ACC_WIDTH:0] prod;
  logic [ACC_WIDTH-1:0] res;
  logic neg, sm, cl, of;
  assign in_ready = state == IDLE;
  // the multiplier works on magnitudes; the sign is restored only once, at accumulate time
  assign prod_s = (neg && sm) ? -partial : partial;
  assign prod = {{(ACC_WIDTH + 1 - 2 * WIDTH){sm & prod_s[2*WIDTH-1]}}, prod_s};
  mac_sat_add #(.ACC_WIDTH(ACC_WIDTH), .SAT(SAT)) u_add (
    .base(cl ? '0 : acc_q),
    .prod(prod),
    .signed_mode(sm),
    .result(res),
    .overflow(of)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      acc_q <= '0;
      ovf <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          mcand <= (signed_mode && a[WIDTH-1]) ? -a : a;
          mplier <= (signed_mode && b[WIDTH-1]) ? -b : b;
          neg <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          sm <= signed_mode;
          cl <= clr;
          cnt <= '0;
          partial <= '0;
          state <= MUL;
        end
        MUL: begin
          if (mplier[0]) partial <= partial + ({{WIDTH{1'b0}}, mcand} << cnt);
          mplier <= mplier >> 1;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) state <= ACC;
        end
        ACC: begin
          acc_q <= res;
          ovf <= (ovf & ~cl) | of;
          out_valid <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_seq_iter.sv
// tb_mac_seq_iter: scoreboard bench driving a saturating and a wrapping instance with identical stimulus.
module tb_mac_seq_iter;
  localparam int W = 4;
  localparam int AW = 12;
  localparam int SMAX = (1 << (AW - 1)) - 1;
  localparam int SMIN = -(1 << (AW - 1));
  localparam int UMAX = (1 << AW) - 1;
  typedef struct {int t; logic [AW-1:0] sa, wa; logic so, wo;} exp_t;
  logic clk = 0, reset = 0, in_valid = 0, signed_mode = 0, clr = 0;
  logic [W-1:0] a = 0, b = 0;
  logic ir0, ir1, ov0, ov1, of0, of1;
  logic [AW-1:0] acc0, acc1;
  exp_t q[$];
  int n_pass = 0, n_total = 0, cyc = 0, n_issued = 0, n_taken = 0, busy = 0;
  logic [AW-1:0] m_sa = 0, m_wa = 0, sh_sa = 0, sh_wa = 0;
  logic m_so = 0, m_wo = 0, sh_so = 0, sh_wo = 0;
  mac_seq_iter #(.WIDTH(W), .ACC_WIDTH(AW), .SAT(1)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir0), .a(a), .b(b),
    .signed_mode(signed_mode), .clr(clr), .acc_q(acc0), .out_valid(ov0), .ovf(of0));
  mac_seq_iter #(.WIDTH(W), .ACC_WIDTH(AW), .SAT(0)) u_wrap (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1), .a(a), .b(b),
    .signed_mode(signed_mode), .clr(clr), .acc_q(acc1), .out_valid(ov1), .ovf(of1));
  always #5 clk = ~clk;
  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", nm, got, got, exp, exp, cyc);
  endfunction
  // reference: integer arithmetic on the interpreted values, then range check and clamp/wrap
  function automatic void step(input bit sat, input logic [AW-1:0] acc, input logic ov,
                               input logic [W-1:0] x, input logic [W-1:0] y, input logic sm,
                               input logic cl, output logic [AW-1:0] nacc, output logic nov);
    int p, base, sum;
    bit o;
    p = sm ? int'($signed(x)) * int'($signed(y)) : int'(x) * int'(y);
    base = cl ? 0 : (sm ? int'($signed(acc)) : int'(acc));
    sum = base + p;
    o = sm ? (sum > SMAX || sum < SMIN) : (sum > UMAX);
    if (sat && o) sum = sm ? (sum > 0 ? SMAX : SMIN) : UMAX;
    nacc = AW'(sum);
    nov = (cl ? 1'b0 : ov) | o;
  endfunction
  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm, input logic cl);
    int g = 0;
    while (!ir0 && g < 40) begin
      in_valid = 1;
      a = W'($urandom);
      b = W'($urandom);
      signed_mode = 1'($urandom);
      clr = 1'($urandom);
      @(negedge clk);
      g++;
    end
    if (!ir0) begin
      chk("accept_timeout", 0, 1);
      $fatal(1, "no accept within bound");
    end
    in_valid = 1;
    a = x;
    b = y;
    signed_mode = sm;
    clr = cl;
    step(1, m_sa, m_so, x, y, sm, cl, m_sa, m_so);
    step(0, m_wa, m_wo, x, y, sm, cl, m_wa, m_wo);
    q.push_back('{cyc + 1, m_sa, m_wa, m_so, m_wo});
    n_issued++;
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) @(negedge clk);
  endtask
  task automatic drain();
    int g = 0;
    in_valid = 0;
    while (q.size() != 0 && g < 40) begin
      @(negedge clk);
      g++;
    end
    chk("drain_pending", q.size(), 0);
    @(negedge clk);
  endtask
  // monitor: timing model for in_ready plus scoreboard pops on out_valid
  always @(posedge clk) begin
    logic rs;
    exp_t e;
    cyc++;
    rs = reset;
    if (!reset) busy = 0;
    else if (n_issued != n_taken) begin
      busy = W + 1;
      n_taken = n_issued;
    end else if (busy > 0) busy--;
    #1;
    if (!rs) begin
      q.delete();
      sh_sa = 0; sh_wa = 0; sh_so = 0; sh_wo = 0;
    end
    chk("in_ready_sat", ir0, busy == 0);
    chk("in_ready_wrap", ir1, busy == 0);
    chk("out_valid_wrap", ov1, ov0);
    if (ov0) begin
      if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
      else begin
        e = q.pop_front();
        chk("latency", cyc - e.t, W + 1);
        sh_sa = e.sa; sh_wa = e.wa; sh_so = e.so; sh_wo = e.wo;
      end
    end
    chk("acc_sat", acc0, sh_sa);
    chk("ovf_sat", of0, sh_so);
    chk("acc_wrap", acc1, sh_wa);
    chk("ovf_wrap", of1, sh_wo);
  end
  initial begin
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    op(15, 15, 0, 1);
    repeat (17) op(15, 15, 0, 0);
    drain();
    chk("plan_u_4050", acc0, 4050);
    chk("plan_u_ovf0", of0, 0);
    op(15, 15, 0, 0);
    drain();
    chk("plan_u_sat", acc0, 12'hFFF);
    chk("plan_u_ovf1", of0, 1);
    chk("plan_wrap_179", acc1, 179);
    chk("plan_wrap_ovf", of1, 1);
    op(4'h8, 4'h8, 1, 1);
    drain();
    chk("plan_s_64", acc0, 64);
    op(4'h8, 4'h7, 1, 0);
    drain();
    chk("plan_s_8", acc0, 8);
    op(4'h8, 4'h7, 1, 1);
    drain();
    chk("plan_s_neg56", acc0, 12'hFC8);
    op(4'h8, 4'h8, 1, 1);
    repeat (30) op(4'h8, 4'h8, 1, 0);
    drain();
    chk("plan_s_1984", acc0, 1984);
    op(4'h8, 4'h8, 1, 0);
    drain();
    chk("plan_s_sat", acc0, 12'h7FF);
    chk("plan_s_ovf1", of0, 1);
    chk("plan_s_wrap", acc1, 12'h800);
    op(1, 1, 1, 1);
    drain();
    chk("plan_clr_acc", acc0, 1);
    chk("plan_clr_ovf", of0, 0);
    op(3, 5, 0, 1);
    drain();
    op(7, 7, 0, 0);
    in_valid = 0;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    reset = 1;
    m_sa = 0; m_wa = 0; m_so = 0; m_wo = 0;
    chk("rst_acc", acc0, 0);
    chk("rst_ovf", of0, 0);
    chk("rst_in_ready", ir0, 1);
    chk("rst_out_valid", ov0, 0);
    idle(10);
    repeat (150) begin
      op(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 8));
    end
    drain();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
